lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Memory-access sequencer between the execute stage and the word-wide data bus.
//  Accepts one load/store per transaction and checks alignment.
//  Stores narrower than XLEN use read-modify-write: lu extracts load data, su merges store bytes.
//  Drives one outstanding word-aligned bus access at a time; returns load data / error to writeback.
// PARAMETERS
//  XLEN  32  data/address width; only 32 is supported (4-byte word, AW = $clog2(XLEN/8) = 2)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  req_valid    in   1     request from execute
//  req_ready    out  1     request accepted when valid&&ready
//  req_we       in   1     1 = store, 0 = load
//  req_funct3   in   3     LB/LH/LW/LBU/LHU or SB/SH/SW (defines.vh encodings)
//  req_addr     in   XLEN  byte address
//  req_wdata    in   XLEN  store data, right-justified
//  resp_valid   out  1     one-cycle completion pulse
//  resp_rdata   out  XLEN  extended load data; 0 for stores/errors
//  resp_err     out  1     misaligned access or illegal funct3
//  mem_req      out  1     bus request, held until mem_ack
//  mem_we       out  1     bus write enable
//  mem_addr     out  XLEN  word-aligned address (low AW bits = 0)
//  mem_wdata    out  XLEN  full merged word
//  mem_ack      in   1     bus completion; mem_rdata valid in the same cycle
//  mem_rdata    in   XLEN  bus read word
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_req=0; mem_we=0;
//    mem_addr=0; mem_wdata=0.
//  States: IDLE, RD, WR, RESP. req_ready = (state==IDLE). mem_req = (state==RD || state==WR).
//  IDLE, on accept: latch we/funct3/addr/wdata.
//    Error check first; if err -> RESP with resp_err=1, no bus access.
//    Store SW -> WR.
//    Any load, SB, SH -> RD.
//  Errors:
//    Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//    Illegal funct3: load funct3 in {3,6,7}; store funct3 > 2.
//  RD: mem_we=0, mem_addr={addr[XLEN-1:2],2'b00}.
//    On mem_ack, capture mem_rdata into the word register.
//    Load -> RESP, resp_rdata = lu(addr[1:0], funct3, mem_rdata).
//    Store -> WR.
//  WR: mem_we=1. mem_wdata = su(addr[1:0], funct3, word_reg, wdata); for SW it is wdata.
//    On mem_ack -> RESP.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE. The new request is accepted on the next cycle.
//  Bus outputs hold stable while mem_req=1 && !mem_ack. Ack may arrive in the first request cycle.
//  mem_ack outside RD/WR is ignored.
//  Latency, accept cycle = 0, ack in first bus cycle:
//    load or SW      -> resp_valid in cycle 2
//    SB/SH           -> resp_valid in cycle 3
//    error           -> resp_valid in cycle 1
//  Reset mid-transaction: next cycle is IDLE and mem_req=0; the aborted write may or may not have
//    landed on the bus. A late ack after reset is ignored.
//  resp_rdata/resp_err hold their last value outside RESP; consumers qualify them with resp_valid.
// STRUCTURE
//  defines.vh: funct3 encodings (LB..LHU, SB/SH/SW) and state encodings.
//  Sub-modules: instantiate existing lu (load extract) and su (store merge) combinationally.
//  Their addr input = latched addr[AW-1:0]. No new sub-module is required.
//  Single always block for the FSM plus registered resp_* outputs.
// TESTING
//  1. Word 0x80112233 at 0x100; LB 0x103 -> one read at mem_addr 0x100; resp_rdata 0xFFFFFF80,
//     err 0; resp_valid in cycle 2.
//  2. Same word; LHU 0x102 -> resp_rdata 0x00008011; LH 0x102 -> 0xFFFF8011.
//  3. Word 0x11223344 at 0x200; SB 0x201 wdata 0x000000AB -> read 0x200, then write
//     mem_wdata 0x1122AB44, mem_we=1; resp_valid after the write ack.
//  4. SW 0x300 wdata 0xDEADBEEF -> single write, no read; SH 0x301 -> resp_err=1, mem_req never high.
//  5. LW 0x100, mem_ack delayed 3 cycles -> mem_req/mem_addr stable for 4 cycles, req_ready=0
//     throughout; one resp_valid pulse.
//  6. rst asserted while in WR for SB -> next cycle IDLE, mem_req=0, req_ready=1, no resp_valid;
//     a stray mem_ack afterwards is ignored.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types, funct3 encodings and the alignment/legality rule for the load/store sequencer.
package lsu_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  // Loads use all five encodings; stores use only B/H/W.
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic access_err(input logic           we,
                                      input logic [2:0]     funct3,
                                      input logic [AW-1:0]  addr);
    logic err;
    err = 1'b1;
    if (we) begin
      case (funct3)
        F3_B:    err = 1'b0;
        F3_H:    err = addr[0];
        F3_W:    err = |addr;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = addr[0];
        F3_W:        err = |addr;
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational byte-lane logic: extracts and extends load data from a bus word (lu)
// and merges narrow store data into a previously read word (su).
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
(
  input  logic [AW-1:0]     addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] ld_word,
  input  logic [DATA_W-1:0] st_word,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] lu_data,
  output logic [DATA_W-1:0] su_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{addr, 3'b000} +: 8];
    ld_half = ld_word[{addr[1], 4'b0000} +: 16];
    lu_data = '0;
    case (funct3)
      F3_B:    lu_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      F3_BU:   lu_data = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_H:    lu_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      F3_HU:   lu_data = {{(DATA_W-16){1'b0}}, ld_half};
      F3_W:    lu_data = ld_word;
      default: lu_data = '0;
    endcase
  end

  always_comb begin
    su_word = st_word;
    case (funct3)
      F3_B:    su_word[{addr, 3'b000} +: 8]     = st_data[7:0];
      F3_H:    su_word[{addr[1], 4'b0000} +: 16] = st_data[15:0];
      F3_W:    su_word = st_data;
      default: su_word = st_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time, alignment check, read-modify-write for
// sub-word stores, single outstanding word-aligned bus access, registered response.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   lu_data;
  logic [XLEN-1:0]   su_word;

  lsu_ctrl_align u_align (
    .addr    (addr_q[AW-1:0]),
    .funct3  (f3_q),
    .ld_word (mem_rdata),
    .st_word (word_q),
    .st_data (wdata_q),
    .lu_data (lu_data),
    .su_word (su_word)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (access_err(req_we, req_funct3, req_addr[AW-1:0])) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_we && req_funct3 == F3_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          word_d = mem_rdata;
          if (we_q) begin
            state_d = ST_WR;
          end else begin
            rdata_d = lu_data;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs derive only from registered state, so they hold steady until the ack.
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_RD) || (state_q == ST_WR);
  assign mem_we     = (state_q == ST_WR);
  assign mem_addr   = {addr_q[XLEN-1:AW], {AW{1'b0}}};
  assign mem_wdata  = (state_q == ST_WR) ? su_word : '0;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
